// File: rtl/ula_pkg.sv
// Shared definitions for the ULA arbiter: op codes, FSM states and field widths.
package ula_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0110;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0111;
  localparam logic [OP_W-1:0] OP_EQ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_MAX = OP_EQ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ula_arbiter_rr.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap-around.
module rr_arbiter
  import ula_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o
);

  logic found;
  int   idx;

  // The last granted requester has the lowest priority on the next search.
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = ID_W'(idx);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ULA between NUM_REQ requesters with round-robin grant and a tagged response.
// Define ULA_ARB_MULWAIT_EN to give multiply a second EXEC cycle.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [OP_W-1:0]           alu_control,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     reqId_q, reqId_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                rspValid_q, rspValid_d;
  logic [ID_W-1:0]     rspId_q, rspId_d;
  logic [DATA_W-1:0]   rspResult_q, rspResult_d;
  logic                rspZero_q, rspZero_d;
  logic                rspErr_q, rspErr_d;
  logic                captureNow;
`ifdef ULA_ARB_MULWAIT_EN
  logic                wait_q, wait_d;
`endif

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     winId;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .id_o    (winId)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      reqId_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= '0;
      rspResult_q <= '0;
      rspZero_q   <= 1'b0;
      rspErr_q    <= 1'b0;
`ifdef ULA_ARB_MULWAIT_EN
      wait_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      reqId_q     <= reqId_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspResult_q <= rspResult_d;
      rspZero_q   <= rspZero_d;
      rspErr_q    <= rspErr_d;
`ifdef ULA_ARB_MULWAIT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    reqId_d     = reqId_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rspValid_d  = rspValid_q;
    rspId_d     = rspId_q;
    rspResult_d = rspResult_q;
    rspZero_d   = rspZero_q;
    rspErr_d    = rspErr_q;
    captureNow  = 1'b0;
`ifdef ULA_ARB_MULWAIT_EN
    wait_d      = wait_q;
`endif
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          op_d    = req_op[winId*OP_W +: OP_W];
          a_d     = req_a[winId*DATA_W +: DATA_W];
          b_d     = req_b[winId*DATA_W +: DATA_W];
          reqId_d = winId;
          ptr_d   = winId;
          state_d = EXEC;
        end
      end
      EXEC: begin
`ifdef ULA_ARB_MULWAIT_EN
        // Multiply is a 2-cycle path through the ULA, so hold operands one extra cycle.
        if (op_q == OP_MUL && !wait_q) begin
          wait_d = 1'b1;
        end else begin
          wait_d     = 1'b0;
          captureNow = 1'b1;
        end
`else
        captureNow = 1'b1;
`endif
        if (captureNow) begin
          rspResult_d = alu_result;
          rspZero_d   = alu_zero;
          rspErr_d    = (op_q > OP_MAX);
          rspId_d     = reqId_q;
          rspValid_d  = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rspValid_q && rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_control = (state_q == IDLE) ? '0 : op_q;
  assign alu_a       = (state_q == IDLE) ? '0 : a_q;
  assign alu_b       = (state_q == IDLE) ? '0 : b_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_id      = rspId_q;
  assign rsp_result  = rspResult_q;
  assign rsp_zero    = rspZero_q;
  assign rsp_err     = rspErr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares the single 32-bit ULA (4-bit op code, A, B in; result and zero flag out) between NUM_REQ requesters.
- Accepts one operation at a time through a per-requester valid/ready handshake and picks the winner round-robin.
- Drives the ULA from registered operands and returns the registered result, tagged with the requester ID, on a response channel.
- Sits between the CPU control/datapath agents and the ULA instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active high.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_op  in  4*NUM_REQ  op code, requester i at bits [4i+3:4i].
- req_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] & req_ready[i].
- alu_control  out  4  to ULA op code.
- alu_a  out  32  to ULA operand A.
- alu_b  out  32  to ULA operand B.
- alu_result  in  32  from ULA.
- alu_zero  in  1  from ULA.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- rsp_result  out  32  captured ULA result.
- rsp_zero  out  1  captured ULA zero flag.
- rsp_err  out  1  op code was outside 0000..1000.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- States and transitions:
  - IDLE: req_ready is the one-hot round-robin winner among the asserted req_valid bits, searched from ptr+1 upward with wrap. The grant is combinational from req_valid and ptr. On transfer, latch op/A/B and the winner ID, set ptr to the winner, then go to EXEC.
  - EXEC: alu_control/alu_a/alu_b come from the latched registers. At the end of the cycle, capture alu_result, alu_zero and err (op > 4'b1000) into the rsp registers, set rsp_valid, then go to RESP (see the optional feature for multiply).
  - RESP: rsp_* held stable while rsp_valid & !rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE.
- req_ready is all-zero outside IDLE and in IDLE when no req_valid is set.
- Throughput is 1 op per 3 cycles with no back-pressure. Latency from transfer to rsp_valid is 2 cycles.
- ULA drive in IDLE is alu_control=0, alu_a=0, alu_b=0. Latched values are driven in EXEC and RESP.
- Illegal op codes are still forwarded to the ULA, which returns 0. They complete normally with rsp_zero=1 and rsp_err=1.
- A requester may drop req_valid before its grant with no side effect. Operands are sampled only on the transfer cycle.
- Several valid requesters in the same cycle: exactly one grant; the others wait. With all requesters continuously valid, grants go 0,1,2,3,0,...
- Reset values: state=IDLE, ptr=NUM_REQ-1 (requester 0 wins first), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, latched op/A/B=0.
- Reset asserted mid-operation discards the in-flight op with no response.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: ULA_ARB_MULWAIT_EN.
- Defined: op 4'b0111 (multiply) stays in EXEC for 2 cycles, because the ULA multiplier is a 2-cycle multicycle path. Operands are held for both cycles, and the capture happens at the end of the second cycle. A 1-bit wait counter is reset to 0. Multiply latency is 3 cycles; other ops are unchanged.
- Undefined: every op spends 1 EXEC cycle and the counter does not exist.

Decomposition:
- Package ula_pkg holds:
  - ULA op code localparams (OP_ADD=0000 .. OP_EQ=1000, OP_MAX=1000).
  - The state enum {IDLE, EXEC, RESP}.
  - The request/response field widths.
- One sub-module, rr_arbiter: purely combinational, inputs req[NUM_REQ] and ptr, outputs one-hot grant and the encoded winner ID. ula_arbiter instantiates it and owns ptr.

Test Plan:
- Single request: after reset, req0 valid, op=0000, A=5, B=7 -> req_ready[0] in the same cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
- Round-robin fairness: all 4 requesters continuously valid with op=0001, A=B=i, rsp_ready=1 -> grant order 0,1,2,3,0; every response has rsp_result=0 and rsp_zero=1; each transfer is 3 cycles apart.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable and req_ready=0 throughout; the next grant comes 1 cycle after rsp_ready rises.
- Illegal op: req2 sends op=1111, A=3, B=3 -> rsp_id=2, rsp_result=0, rsp_zero=1, rsp_err=1.
- Reset mid-operation: rst asserted in EXEC -> no rsp_valid; busy=0 next cycle; with requesters 1 and 0 both valid afterwards, requester 0 is granted first.
- With ULA_ARB_MULWAIT_EN: op=0111, A=6, B=7 -> rsp_valid 3 cycles after the transfer with rsp_result=42. Without the macro -> 2 cycles.
